alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single 8-bit ALU between two requesters, e.g. the CPU execute stage (port 0) and a debug/microcode sequencer (port 1). It accepts one operation at a time through a valid/ready handshake, using round-robin grant. It holds the ALU inputs stable for a programmable settle window and captures `RESULT` into a registered response. Reserved ALUOPs are rejected without touching the ALU.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1: clock cycles ALU inputs are held before `RESULT` is sampled. Legal range is 1–15.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RESET` in 1: synchronous, active-low reset.
- `REQ_VALID` in 2: per-port request valid; bit i belongs to port i.
- `REQ_READY` out 2: per-port accept; at most one bit high.
- `REQ_DATA1` in 16: operand 1 for each port; bits [8i+7:8i] belong to port i.
- `REQ_DATA2` in 16: operand 2 for each port, same packing.
- `REQ_SELECT` in 6: ALUOP for each port; bits [3i+2:3i] belong to port i.
- `RSP_VALID` out 2: one-hot response valid, naming the owning port.
- `RSP_READY` in 2: per-port response accept.
- `RSP_RESULT` out 8: result of the owning port's operation.
- `RSP_ERR` out 1: high when the operation used a reserved ALUOP.
- `ALU_DATA1` out 8: to ALU `DATA1`.
- `ALU_DATA2` out 8: to ALU `DATA2`.
- `ALU_SELECT` out 3: to ALU `SELECT`.
- `ALU_RESULT` in 8: from ALU `RESULT`.

## Operation
- FSM states are IDLE, EXEC and RESP. Reset enters IDLE.
- Grant (combinational, IDLE only):
  - If only one port is valid, grant it.
  - If both are valid, grant the port named by the priority pointer `PRI`.
  - `REQ_READY[i]` = (state==IDLE) & grant[i] & RESET.
- Handshake: a transfer occurs on a rising edge with `REQ_VALID[i] & REQ_READY[i]`. On transfer:
  - Latch DATA1, DATA2, SELECT and owner id.
  - Load counter `CNT` = `SETTLE_CYCLES`.
- IDLE transitions:
  - Accepted op with `SELECT[2]==0` → EXEC.
  - Accepted op with `SELECT[2]==1` (reserved) → RESP with `RSP_ERR`=1 and `RSP_RESULT`=8'h00. ALU outputs remain unchanged.
- EXEC:
  - `ALU_*` are driven from the latched registers.
  - `CNT` decrements each cycle.
  - On the edge where `CNT`==1: `RSP_RESULT` ← `ALU_RESULT`, `RSP_ERR` ← 0, → RESP.
- RESP:
  - `RSP_VALID[owner]`=1, and `RSP_RESULT`/`RSP_ERR` are held stable.
  - On an edge with `RSP_READY[owner]`: → IDLE and `PRI` ← ~owner.
  - `RSP_READY` of the non-owner is ignored.
- `PRI` updates only on response completion, so a port that was just served loses the next tie.
- Requester inputs are ignored outside IDLE. A requester must hold `REQ_VALID` and its fields until accepted.
- `ALU_*` keep their last values in IDLE and RESP. They never change while in EXEC.

## Timing
- Reset (`RESET`=0 at an edge, in any state, including mid-EXEC or RESP):
  - State → IDLE; any in-flight op is dropped with no response.
  - `REQ_READY`=0 while reset is asserted.
  - `RSP_VALID`=2'b00, `RSP_RESULT`=8'h00, `RSP_ERR`=0.
  - `ALU_DATA1`=`ALU_DATA2`=8'h00, `ALU_SELECT`=3'b000.
  - `PRI`=0, `CNT`=0.
- Latency for a normal op: accept edge T; `RSP_VALID` rises after edge T+`SETTLE_CYCLES`.
- Latency for a reserved op: `RSP_VALID` rises after edge T.
- Next accept is possible on the same edge that completes the response only if it is the edge after RESP exits. Minimum spacing between accepts is `SETTLE_CYCLES`+2 edges.
- `SETTLE_CYCLES` must cover the worst ALU delay: the ADD path, 2 time units.

## Structure
- Shared header `alu_defs.vh` holds:
  - ALUOP constants FWD=3'b000, ADD=3'b001, AND=3'b010, OR=3'b011, with reserved codes defined as `SELECT[2]`=1.
  - State encodings IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
- One sub-module, `rr_arb2`: combinational 2-way round-robin grant from `REQ_VALID`, `PRI` and an enable. The FSM, counter and registers stay in `alu_arbiter`.

## Test plan
- Reset mid-EXEC: port0 ADD 8'h05+8'h03 accepted, reset on the next edge → `RSP_VALID`=00, `ALU_SELECT`=000, `PRI`=0, no response delivered.
- Single op: port0 ADD 8'h05+8'h03, `SETTLE_CYCLES`=1 → after accept edge T, `RSP_VALID`=01 and `RSP_RESULT`=8'h08 after T+1. `RSP_READY` held low for 3 cycles → output stable. Release → IDLE.
- Contention: both ports valid at reset exit:
  - port0 AND 8'hF0&8'h3C → 8'h30, served first.
  - port1 OR 8'hF0|8'h3C → 8'hFC, served next.
  - port0 re-request, both valid again → port1 wins the following tie.
- Reserved op: port1 SELECT=3'b101 → `RSP_VALID`=10 after accept edge, `RSP_ERR`=1, `RSP_RESULT`=8'h00. `ALU_SELECT` unchanged from the previous value.
- Settle window: `SETTLE_CYCLES`=3, FWD with DATA2=8'hA5 → `ALU_*` constant for 3 cycles, `RSP_RESULT`=8'hA5. Overflow ADD 8'hFF+8'h02 → 8'h01.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: ALU opcodes, FSM states
// and the latched operation record that drives the ALU pins.
package alu_arbiter_pkg;

  // ALU operation codes; every code with bit 2 set is reserved.
  typedef enum logic [2:0] {
    ALUOP_FWD = 3'b000,
    ALUOP_ADD = 3'b001,
    ALUOP_AND = 3'b010,
    ALUOP_OR  = 3'b011
  } aluop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] data1;
    logic [7:0] data2;
    logic [2:0] sel;
  } alu_op_t;

  // Reserved opcodes never reach the ALU.
  function automatic logic is_reserved(input logic [2:0] sel);
    return sel[2];
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to
// the port named by the priority pointer. Purely combinational.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       pri,
  input  logic       en,
  output logic [1:0] grant
);

  // Grant at most one port, and only while enabled.
  always_comb begin
    grant    = 2'b00;
    grant[0] = en & valid[0] & (~valid[1] | ~pri);
    grant[1] = en & valid[1] & (~valid[0] |  pri);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 8-bit ALU between two requesters. One operation is in flight
// at a time: accept in IDLE, hold ALU inputs for SETTLE_CYCLES in EXEC,
// then present a registered response in RESP until the owner takes it.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  REQ_VALID,
  output logic [1:0]  REQ_READY,
  input  logic [15:0] REQ_DATA1,
  input  logic [15:0] REQ_DATA2,
  input  logic [5:0]  REQ_SELECT,
  output logic [1:0]  RSP_VALID,
  input  logic [1:0]  RSP_READY,
  output logic [7:0]  RSP_RESULT,
  output logic        RSP_ERR,
  output logic [7:0]  ALU_DATA1,
  output logic [7:0]  ALU_DATA2,
  output logic [2:0]  ALU_SELECT,
  input  logic [7:0]  ALU_RESULT
);

  // Out-of-range settings are pulled into 1..15 so the counter always
  // terminates and fits in four bits.
  localparam int unsigned SETTLE_CLAMP =
    (SETTLE_CYCLES < 1) ? 1 : ((SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES);
  localparam logic [3:0] SETTLE_LD = SETTLE_CLAMP[3:0];

  state_t     state_q, state_d;
  alu_op_t    op_q, op_d;
  alu_op_t    req_op;
  logic       owner_q, owner_d;
  logic       pri_q, pri_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rsp_result_q, rsp_result_d;
  logic       rsp_err_q, rsp_err_d;

  logic [1:0] grant;
  logic       arb_en;
  logic       xfer;
  logic       sel_port;
  logic       rsp_ready_own;

  // Grants are only offered in IDLE and never while reset is asserted.
  assign arb_en = (state_q == ST_IDLE) & RESET;

  rr_arb2 u_arb (
    .valid (REQ_VALID),
    .pri   (pri_q),
    .en    (arb_en),
    .grant (grant)
  );

  assign REQ_READY     = grant;
  assign xfer          = |(REQ_VALID & grant);
  assign sel_port      = grant[1];
  assign rsp_ready_own = owner_q ? RSP_READY[1] : RSP_READY[0];

  assign ALU_DATA1  = op_q.data1;
  assign ALU_DATA2  = op_q.data2;
  assign ALU_SELECT = op_q.sel;
  assign RSP_RESULT = rsp_result_q;
  assign RSP_ERR    = rsp_err_q;

  // Pick the granted port's operand bytes and opcode out of the packed buses.
  always_comb begin
    req_op.data1 = sel_port ? REQ_DATA1[15:8]  : REQ_DATA1[7:0];
    req_op.data2 = sel_port ? REQ_DATA2[15:8]  : REQ_DATA2[7:0];
    req_op.sel   = sel_port ? REQ_SELECT[5:3]  : REQ_SELECT[2:0];
  end

  // State register; reset drops any in-flight operation.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: reserved ops skip EXEC and answer at once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          state_d = is_reserved(req_op.sel) ? ST_RESP : ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_own) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response valid is one-hot on the owning port while in RESP.
  always_comb begin
    RSP_VALID = 2'b00;
    if (state_q == ST_RESP) begin
      RSP_VALID = owner_q ? 2'b10 : 2'b01;
    end
  end

  // Datapath next values: latch on accept, count down the settle window,
  // capture the ALU result, and hand priority away on completion.
  always_comb begin
    op_d         = op_q;
    owner_d      = owner_q;
    pri_d        = pri_q;
    cnt_d        = cnt_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          owner_d = sel_port;
          cnt_d   = SETTLE_LD;
          if (is_reserved(req_op.sel)) begin
            // ALU pins keep their previous operation.
            rsp_result_d = 8'h00;
            rsp_err_d    = 1'b1;
          end else begin
            op_d = req_op;
          end
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          rsp_result_d = ALU_RESULT;
          rsp_err_d    = 1'b0;
        end
      end
      ST_RESP: begin
        if (rsp_ready_own) begin
          // The port just served loses the next tie.
          pri_d = ~owner_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers, all cleared by reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      op_q         <= '0;
      owner_q      <= 1'b0;
      pri_q        <= 1'b0;
      cnt_q        <= 4'd0;
      rsp_result_q <= 8'h00;
      rsp_err_q    <= 1'b0;
    end else begin
      op_q         <= op_d;
      owner_q      <= owner_d;
      pri_q        <= pri_d;
      cnt_q        <= cnt_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: one instance with a one-cycle settle window and one
// with a three-cycle window, each driving its own behavioural ALU.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk;
  logic        a_rst, b_rst;
  logic [1:0]  a_req_valid, a_req_ready, b_req_valid, b_req_ready;
  logic [15:0] a_d1, a_d2, b_d1, b_d2;
  logic [5:0]  a_sel, b_sel;
  logic [1:0]  a_rsp_valid, a_rsp_ready, b_rsp_valid, b_rsp_ready;
  logic [7:0]  a_rsp_result, b_rsp_result;
  logic        a_rsp_err, b_rsp_err;
  logic [7:0]  a_alu_d1, a_alu_d2, a_alu_res, b_alu_d1, b_alu_d2, b_alu_res;
  logic [2:0]  a_alu_sel, b_alu_sel;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] last_sel;

  typedef struct {
    logic       port;
    logic [2:0] op;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] exp_res;
    logic       exp_err;
  } vec_t;

  vec_t vt[8];

  function automatic logic [7:0] alu_model(input logic [2:0] s, input logic [7:0] x,
                                           input logic [7:0] y);
    logic [7:0] r;
    case (s)
      ALUOP_FWD: r = y;
      ALUOP_ADD: r = x + y;
      ALUOP_AND: r = x & y;
      ALUOP_OR:  r = x | y;
      default:   r = 8'hDE;
    endcase
    return r;
  endfunction

  assign a_alu_res = alu_model(a_alu_sel, a_alu_d1, a_alu_d2);
  assign b_alu_res = alu_model(b_alu_sel, b_alu_d1, b_alu_d2);

  alu_arbiter #(.SETTLE_CYCLES(1)) dut_a (
    .CLK(clk), .RESET(a_rst),
    .REQ_VALID(a_req_valid), .REQ_READY(a_req_ready),
    .REQ_DATA1(a_d1), .REQ_DATA2(a_d2), .REQ_SELECT(a_sel),
    .RSP_VALID(a_rsp_valid), .RSP_READY(a_rsp_ready),
    .RSP_RESULT(a_rsp_result), .RSP_ERR(a_rsp_err),
    .ALU_DATA1(a_alu_d1), .ALU_DATA2(a_alu_d2), .ALU_SELECT(a_alu_sel),
    .ALU_RESULT(a_alu_res)
  );

  alu_arbiter #(.SETTLE_CYCLES(3)) dut_b (
    .CLK(clk), .RESET(b_rst),
    .REQ_VALID(b_req_valid), .REQ_READY(b_req_ready),
    .REQ_DATA1(b_d1), .REQ_DATA2(b_d2), .REQ_SELECT(b_sel),
    .RSP_VALID(b_rsp_valid), .RSP_READY(b_rsp_ready),
    .RSP_RESULT(b_rsp_result), .RSP_ERR(b_rsp_err),
    .ALU_DATA1(b_alu_d1), .ALU_DATA2(b_alu_d2), .ALU_SELECT(b_alu_sel),
    .ALU_RESULT(b_alu_res)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One single-port transaction on dut_a, checked end to end.
  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    logic [1:0] onehot;
    onehot      = v.port ? 2'b10 : 2'b01;
    a_req_valid = onehot;
    a_d1  = v.port ? {v.x, 8'hEE} : {8'hEE, v.x};
    a_d2  = v.port ? {v.y, 8'h77} : {8'h77, v.y};
    a_sel = v.port ? {v.op, 3'b011} : {3'b011, v.op};
    #1;
    check($sformatf("v%0d req_ready", idx), a_req_ready, onehot);
    tick();
    a_req_valid = 2'b00;
    if (!v.exp_err) begin
      check($sformatf("v%0d alu_in", idx), {a_alu_sel, a_alu_d1, a_alu_d2}, {v.op, v.x, v.y});
      last_sel = v.op;
    end else begin
      check($sformatf("v%0d alu_sel_kept", idx), a_alu_sel, last_sel);
    end
    lat = 0;
    while (a_rsp_valid == 2'b00 && lat < 20) begin
      tick();
      lat++;
    end
    check($sformatf("v%0d latency", idx), lat, v.exp_err ? 0 : 1);
    check($sformatf("v%0d rsp_valid", idx), a_rsp_valid, onehot);
    check($sformatf("v%0d result", idx), a_rsp_result, v.exp_res);
    check($sformatf("v%0d err", idx), a_rsp_err, v.exp_err);
    a_rsp_ready = onehot;
    tick();
    a_rsp_ready = 2'b00;
    check($sformatf("v%0d rsp_done", idx), a_rsp_valid, 2'b00);
  endtask

  // One port-0 transaction on dut_b, checking the ALU pins never move in EXEC.
  task automatic run_b(input string name, input logic [2:0] op, input logic [7:0] x,
                       input logic [7:0] y, input logic [7:0] exp_res);
    int lat;
    b_req_valid = 2'b01;
    b_d1  = {8'h55, x};
    b_d2  = {8'h66, y};
    b_sel = {3'b010, op};
    #1;
    check({name, " req_ready"}, b_req_ready, 2'b01);
    tick();
    b_req_valid = 2'b00;
    lat = 0;
    while (b_rsp_valid == 2'b00 && lat < 20) begin
      check($sformatf("%s hold%0d", name, lat), {b_alu_sel, b_alu_d1, b_alu_d2}, {op, x, y});
      tick();
      lat++;
    end
    check({name, " latency"}, lat, 3);
    check({name, " rsp_valid"}, b_rsp_valid, 2'b01);
    check({name, " result"}, b_rsp_result, exp_res);
    check({name, " err"}, b_rsp_err, 1'b0);
    b_rsp_ready = 2'b01;
    tick();
    b_rsp_ready = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b0, 3'b001, 8'h05, 8'h03, 8'h08, 1'b0};
    vt[1] = '{1'b1, 3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0};
    vt[2] = '{1'b0, 3'b011, 8'hF0, 8'h3C, 8'hFC, 1'b0};
    vt[3] = '{1'b1, 3'b000, 8'h11, 8'hA5, 8'hA5, 1'b0};
    vt[4] = '{1'b0, 3'b001, 8'hFF, 8'h02, 8'h01, 1'b0};
    vt[5] = '{1'b1, 3'b101, 8'h12, 8'h34, 8'h00, 1'b1};
    vt[6] = '{1'b0, 3'b111, 8'h9A, 8'hBC, 8'h00, 1'b1};
    vt[7] = '{1'b1, 3'b001, 8'h80, 8'h80, 8'h00, 1'b0};

    clk = 1'b0;
    a_rst = 1'b0; b_rst = 1'b0;
    a_req_valid = 2'b01; a_d1 = 16'h0005; a_d2 = 16'h0003; a_sel = 6'b000001;
    a_rsp_ready = 2'b00;
    b_req_valid = 2'b00; b_d1 = '0; b_d2 = '0; b_sel = '0; b_rsp_ready = 2'b00;
    last_sel = 3'b000;

    // Reset state, with a request pending to show REQ_READY stays low.
    tick();
    tick();
    check("rst req_ready", a_req_ready, 2'b00);
    check("rst rsp_valid", a_rsp_valid, 2'b00);
    check("rst rsp", {a_rsp_result, a_rsp_err}, 9'h000);
    check("rst alu", {a_alu_sel, a_alu_d1, a_alu_d2}, 19'h0);
    check("rst b rsp_valid", b_rsp_valid, 2'b00);

    // Reset mid-EXEC drops the operation.
    a_rst = 1'b1;
    #1;
    check("mid req_ready", a_req_ready, 2'b01);
    tick();
    a_req_valid = 2'b00;
    check("mid alu_sel", a_alu_sel, 3'b001);
    a_rst = 1'b0;
    tick();
    check("mid rst rsp_valid", a_rsp_valid, 2'b00);
    check("mid rst alu", {a_alu_sel, a_alu_d1, a_alu_d2}, 19'h0);
    a_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid no_rsp%0d", i), a_rsp_valid, 2'b00);
    end

    // Single op, response held while the owner is not ready.
    a_req_valid = 2'b01; a_d1 = 16'h0005; a_d2 = 16'h0003; a_sel = 6'b000001;
    #1;
    check("single req_ready", a_req_ready, 2'b01);
    tick();
    a_req_valid = 2'b00;
    tick();
    check("single rsp_valid", a_rsp_valid, 2'b01);
    check("single result", a_rsp_result, 8'h08);
    a_req_valid = 2'b10;
    a_rsp_ready = 2'b10;
    #1;
    check("single busy req_ready", a_req_ready, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("single hold%0d", i), {a_rsp_valid, a_rsp_result, a_rsp_err},
            {2'b01, 8'h08, 1'b0});
    end
    a_req_valid = 2'b00;
    a_rsp_ready = 2'b01;
    tick();
    a_rsp_ready = 2'b00;
    check("single done", a_rsp_valid, 2'b00);

    // Contention at reset exit: port 0 first, then port 1, then port 1 wins the tie.
    a_rst = 1'b0;
    tick();
    a_rst = 1'b1;
    a_req_valid = 2'b11; a_d1 = 16'hF0F0; a_d2 = 16'h3C3C; a_sel = 6'b011010;
    #1;
    check("cont grant0", a_req_ready, 2'b01);
    tick();
    a_req_valid = 2'b10;
    #1;
    check("cont busy", a_req_ready, 2'b00);
    tick();
    check("cont rsp0", {a_rsp_valid, a_rsp_result}, {2'b01, 8'h30});
    a_rsp_ready = 2'b01;
    tick();
    a_rsp_ready = 2'b00;
    a_req_valid = 2'b11; a_d1 = 16'hF005; a_d2 = 16'h3C03; a_sel = 6'b011001;
    #1;
    check("cont tie port1", a_req_ready, 2'b10);
    tick();
    a_req_valid = 2'b01;
    tick();
    check("cont rsp1", {a_rsp_valid, a_rsp_result}, {2'b10, 8'hFC});
    a_rsp_ready = 2'b10;
    tick();
    a_rsp_ready = 2'b00;
    #1;
    check("cont grant0 again", a_req_ready, 2'b01);
    tick();
    a_req_valid = 2'b00;
    tick();
    check("cont rsp0 again", {a_rsp_valid, a_rsp_result}, {2'b01, 8'h08});
    a_rsp_ready = 2'b01;
    tick();
    a_rsp_ready = 2'b00;
    last_sel = 3'b001;

    // Table of single-port operations, including reserved opcodes.
    for (int i = 0; i < 8; i++) begin
      run_vec(i, vt[i]);
    end

    // Three-cycle settle window.
    b_rst = 1'b1;
    tick();
    run_b("b fwd", 3'b000, 8'h00, 8'hA5, 8'hA5);
    run_b("b add", 3'b001, 8'hFF, 8'h02, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
